uc_multiciclo: RTL and testbench
================================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: reset acts immediately when low, regardless of clk.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 zero  input  1  registered zero flag from the datapath.
REQ-006 run  input  1  high = allow the next instruction to be fetched.
REQ-007 s_inc  output  1  PC source select: 1 = PC+1, 0 = jump target.
REQ-008 s_inm  output  1  operand select: 1 = immediate, 0 = register.
REQ-009 we  output  1  register-file write enable.
REQ-010 wez  output  1  zero-flag write enable.
REQ-011 ALUOp  output  3  ALU operation.
REQ-012 pc_en  output  1  PC register load enable.
REQ-013 halted  output  1  high while in state HALT.
REQ-014 illegal  output  1  sticky flag: an undefined opcode was executed.

Function
REQ-015 SHALL implement the states INIT, FETCH, EXEC and HALT, encoded in 2 bits.
REQ-016 INIT -> FETCH unconditionally after one cycle; this absorbs program-memory read latency.
REQ-017 FETCH -> EXEC when run=1; FETCH holds when run=0.
REQ-018 EXEC -> HALT if Opcode=6'b010011; otherwise EXEC -> FETCH.
REQ-019 HALT holds until reset.
REQ-020 In INIT, FETCH and HALT the outputs SHALL be: pc_en=0, we=0, wez=0, s_inc=1, s_inm=0, ALUOp=000.
REQ-021 In EXEC, the outputs SHALL be decoded combinationally from Opcode and zero, with pc_en=1 except for HALT; each instruction therefore takes 2 cycles (FETCH + EXEC).
REQ-022 Opcode[5]=1 (ALU reg-reg): ALUOp=Opcode[4:2], s_inm=0, we=1, wez=1, s_inc=1.
REQ-023 Opcode[5:2]=4'b0000 (load immediate): s_inm=1, ALUOp=000, we=1, wez=0, s_inc=1.
REQ-024 Opcode=6'b010000 (J): s_inc=0, we=0, wez=0.
REQ-025 Opcode=6'b010001 (JZ): s_inc=~zero, we=0, wez=0.
REQ-026 Opcode=6'b010010 (JNZ): s_inc=zero, we=0, wez=0.
REQ-027 Opcode=6'b010011 (HALT): pc_en=0, we=0, wez=0.
REQ-028 Every other opcode SHALL execute as a NOP (s_inc=1, we=0, wez=0, pc_en=1) and set illegal at the EXEC clock edge; illegal remains set until reset.
REQ-029 halted SHALL be a registered output, high on the cycle after the EXEC edge of a HALT instruction.
REQ-030 The zero input SHALL be sampled only in EXEC; changes of zero in other states have no effect.

Reset
REQ-031 reset=0 SHALL force state INIT, illegal=0, halted=0, and every control output to its REQ-020 value, asynchronously.
REQ-032 reset asserted mid-EXEC SHALL drop we, wez and pc_en immediately; no partial write is permitted.
REQ-033 After reset is released, the first EXEC SHALL occur no earlier than the third rising edge.

Configuration
REQ-034 Macro UC_PERF_CNT_EN: when defined, the block SHALL add output retired [15:0], cleared by reset and incremented once per completed EXEC (including NOP and HALT), wrapping from 16'hFFFF to 0.
REQ-035 When UC_PERF_CNT_EN is undefined, the retired port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Release reset with run=1 and Opcode=6'b100110 -> INIT, FETCH, EXEC; in EXEC: ALUOp=001, we=1, wez=1, pc_en=1.
REQ-037 Opcode=6'b010001 with zero=1 -> s_inc=0; repeat with zero=0 -> s_inc=1, pc_en=1.
REQ-038 run=0 for 5 cycles while in FETCH -> state stays FETCH and pc_en=0 throughout; run=1 -> EXEC on the next edge.
REQ-039 Opcode=6'b010011 -> pc_en=0 in EXEC, halted=1 next cycle, and it stays set for 10 cycles despite any Opcode.
REQ-040 Opcode=6'b010101 -> NOP outputs, illegal=1 and sticky; assert reset=0 mid-EXEC -> we=0 and illegal=0 immediately.
REQ-041 With UC_PERF_CNT_EN defined, preload the counter to 16'hFFFE and execute 3 instructions -> retired=16'h0001.

Source files
------------

// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle control unit (INIT / FETCH / EXEC / HALT).
// Each instruction takes a FETCH cycle followed by an EXEC cycle. Control
// outputs are idle outside EXEC and are decoded from Opcode/zero inside EXEC.
// Optional feature: define UC_PERF_CNT_EN to add the 16-bit 'retired'
// counter, which counts completed EXEC cycles.
module uc_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       zero,
    input  logic       run,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we,
    output logic       wez,
    output logic [2:0] ALUOp,
    output logic       pc_en,
    output logic       halted,
    output logic       illegal
`ifdef UC_PERF_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_HALT = 6'b010011;

    state_t r_state;
    state_t w_next;
    logic   r_halted;
    logic   r_illegal;
    logic   w_is_halt;
    logic   w_is_illegal;

    // State register; reset drops the FSM back to INIT immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_INIT;
        else        r_state <= w_next;
    end

    // Next-state logic: INIT waits one cycle for program memory, FETCH waits for run.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT:  w_next = ST_FETCH;
            ST_FETCH: w_next = run ? ST_EXEC : ST_FETCH;
            ST_EXEC:  w_next = w_is_halt ? ST_HALT : ST_FETCH;
            ST_HALT:  w_next = ST_HALT;
            default:  w_next = ST_INIT;
        endcase
    end

    // Output decode: idle values everywhere except EXEC, where Opcode and zero select the controls.
    always_comb begin
        s_inc        = 1'b1;
        s_inm        = 1'b0;
        we           = 1'b0;
        wez          = 1'b0;
        ALUOp        = 3'b000;
        pc_en        = 1'b0;
        w_is_halt    = 1'b0;
        w_is_illegal = 1'b0;
        if (r_state == ST_EXEC) begin
            pc_en = 1'b1;
            casez (Opcode)
                6'b1?????: begin
                    ALUOp = Opcode[4:2];
                    we    = 1'b1;
                    wez   = 1'b1;
                end
                6'b0000??: begin
                    s_inm = 1'b1;
                    we    = 1'b1;
                end
                OP_J:    s_inc = 1'b0;
                OP_JZ:   s_inc = ~zero;
                OP_JNZ:  s_inc = zero;
                OP_HALT: begin
                    pc_en     = 1'b0;
                    w_is_halt = 1'b1;
                end
                // Undefined opcodes behave as a NOP but are flagged.
                default: w_is_illegal = 1'b1;
            endcase
        end
    end

    // Registered halted flag, set by the EXEC edge of a HALT instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               r_halted <= 1'b0;
        else if (r_state == ST_EXEC && w_is_halt) r_halted <= 1'b1;
    end

    // Sticky illegal flag, set by the EXEC edge of an undefined opcode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  r_illegal <= 1'b0;
        else if (r_state == ST_EXEC && w_is_illegal) r_illegal <= 1'b1;
    end

    assign halted  = r_halted;
    assign illegal = r_illegal;

`ifdef UC_PERF_CNT_EN
    logic [15:0] r_retired;

    // Retired-instruction counter: one count per completed EXEC, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_retired <= 16'h0000;
        else if (r_state == ST_EXEC) r_retired <= r_retired + 16'h0001;
    end

    assign retired = r_retired;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo with a behavioural reference model.
module tb_uc_multiciclo;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       zero;
    logic       run;
    logic       s_inc, s_inm, we, wez, pc_en, halted, illegal;
    logic [2:0] ALUOp;
`ifdef UC_PERF_CNT_EN
    logic [15:0] retired;
    int          m_retired = 0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    uc_multiciclo dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .zero    (zero),
        .run     (run),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we      (we),
        .wez     (wez),
        .ALUOp   (ALUOp),
        .pc_en   (pc_en),
        .halted  (halted),
        .illegal (illegal)
`ifdef UC_PERF_CNT_EN
        ,
        .retired (retired)
`endif
    );

    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {s_inc, s_inm, we, wez, ALUOp, pc_en, halted, illegal};

    localparam logic [10:0] IDLE = 11'b1_0_0_0_000_0_0_0;

    // ---------------- reference model ----------------
    // Phase of the current instruction as the programmer sees it.
    localparam int PH_WARMUP = 0;  // first cycle after reset
    localparam int PH_WAIT   = 1;  // waiting for run to fetch
    localparam int PH_RUN    = 2;  // instruction executing this cycle
    localparam int PH_STOP   = 3;  // machine stopped
    int m_phase   = PH_WARMUP;
    bit m_halted  = 1'b0;
    bit m_illegal = 1'b0;

    function automatic bit op_defined(int op);
        return (op >= 32) || (op < 4) || (op >= 16 && op <= 19);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase   = PH_WARMUP;
            m_halted  = 1'b0;
            m_illegal = 1'b0;
`ifdef UC_PERF_CNT_EN
            m_retired = 0;
`endif
        end else begin
            if (m_phase == PH_WARMUP) m_phase = PH_WAIT;
            else if (m_phase == PH_WAIT) begin
                if (run) m_phase = PH_RUN;
            end else if (m_phase == PH_RUN) begin
`ifdef UC_PERF_CNT_EN
                m_retired = (m_retired + 1) % 65536;
`endif
                if (!op_defined(int'(Opcode))) m_illegal = 1'b1;
                if (int'(Opcode) == 19) begin
                    m_phase  = PH_STOP;
                    m_halted = 1'b1;
                end else m_phase = PH_WAIT;
            end
        end
    end

    function automatic logic [10:0] model_out();
        int         op;
        logic       si, sm, w, wz, pe;
        logic [2:0] a;
        op = int'(Opcode);
        si = 1'b1; sm = 1'b0; w = 1'b0; wz = 1'b0; a = 3'b000; pe = 1'b0;
        if (m_phase == PH_RUN) begin
            pe = 1'b1;
            if (op >= 32) begin
                a  = 3'((op / 4) % 8);
                w  = 1'b1;
                wz = 1'b1;
            end else if (op < 4) begin
                sm = 1'b1;
                w  = 1'b1;
            end else if (op == 16) si = 1'b0;
            else if (op == 17) si = ~zero;
            else if (op == 18) si = zero;
            else if (op == 19) pe = 1'b0;
        end
        return {si, sm, w, wz, a, pe, m_halted, m_illegal};
    endfunction

    // Leaves the bench at a falling edge with reset released; DUT in INIT.
    task automatic reset_dut();
        reset = 1'b0; run = 1'b0; Opcode = 6'd0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Opcode = 6'($urandom_range(0, 63)); run = 1'($urandom); zero = 1'($urandom);
            @(negedge clk); #1;
            n_tests++;
            if (obs !== IDLE) begin
                n_fail++;
                $display("FAIL reset_outputs: got %b expected %b", obs, IDLE);
            end
        end
    endtask

    task automatic test_alu_regreg();
        reset_dut();
        run = 1'b1; Opcode = 6'b100110;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL alu_seq_cycle%0d: got %b expected %b", c, obs, model_out());
            end
            if (c < 2) @(negedge clk);
        end
        n_tests++;
        if ({ALUOp, we, wez, pc_en} !== 6'b001_1_1_1) begin
            n_fail++;
            $display("FAIL alu_exec: got %b expected %b", {ALUOp, we, wez, pc_en}, 6'b001111);
        end
        @(negedge clk);
    endtask

    task automatic test_jumps();
        logic [5:0] ops [6] = '{6'b010001, 6'b010001, 6'b010010, 6'b010010, 6'b010000, 6'b000010};
        logic       zs  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] want[6] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11};
        reset_dut();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            Opcode = ops[i]; zero = zs[i]; run = 1'b1;
            @(negedge clk); #1;
            n_tests++;
            if (obs !== model_out() || {s_inc, pc_en} !== want[i]) begin
                n_fail++;
                $display("FAIL jump_%0d op=%b zero=%b: got %b expected %b", i, ops[i], zs[i], obs, model_out());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_stall();
        reset_dut();
        @(negedge clk);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Opcode = 6'($urandom_range(0, 63)); zero = 1'($urandom);
            #1;
            n_tests++;
            if (obs !== IDLE || obs !== model_out()) begin
                n_fail++;
                $display("FAIL stall_%0d: got %b expected %b", i, obs, IDLE);
            end
            @(negedge clk);
        end
        run = 1'b1; Opcode = 6'b100000;
        @(negedge clk); #1;
        n_tests++;
        if (pc_en !== 1'b1 || we !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got pc_en=%b we=%b expected 1 1", pc_en, we);
        end
        @(negedge clk);
    endtask

    task automatic test_halt();
        reset_dut();
        @(negedge clk);
        run = 1'b1; Opcode = 6'b010011;
        @(negedge clk); #1;
        n_tests++;
        if (pc_en !== 1'b0 || halted !== 1'b0 || obs !== model_out()) begin
            n_fail++;
            $display("FAIL halt_exec: got %b expected %b", obs, model_out());
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            Opcode = 6'($urandom_range(0, 63)); run = 1'($urandom); zero = 1'($urandom);
            #1;
            n_tests++;
            if (obs !== (IDLE | 11'b10) || obs !== model_out()) begin
                n_fail++;
                $display("FAIL halt_hold_%0d: got %b expected %b", i, obs, IDLE | 11'b10);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal_reset();
        reset_dut();
        @(negedge clk);
        run = 1'b1; Opcode = 6'b010101;
        @(negedge clk); #1;
        n_tests++;
        if (obs !== 11'b1_0_0_0_000_1_0_0) begin
            n_fail++;
            $display("FAIL illegal_nop: got %b expected %b", obs, 11'b10000001000);
        end
        @(negedge clk); #1;
        n_tests++;
        if (illegal !== 1'b1 || obs !== model_out()) begin
            n_fail++;
            $display("FAIL illegal_set: got %b expected %b", obs, model_out());
        end
        Opcode = 6'b100001;
        @(negedge clk); #1;
        n_tests++;
        if (we !== 1'b1 || illegal !== 1'b1 || obs !== model_out()) begin
            n_fail++;
            $display("FAIL illegal_sticky: got %b expected %b", obs, model_out());
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (obs !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_exec: got %b expected %b", obs, IDLE);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        int stopped = 0;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            Opcode = 6'($urandom_range(0, 63));
            run    = ($urandom_range(0, 3) != 0);
            zero   = 1'($urandom);
            #1;
            n_tests++;
            if (obs !== model_out()) begin
                n_fail++;
                $display("FAIL random_%0d op=%b zero=%b run=%b: got %b expected %b",
                         i, Opcode, zero, run, obs, model_out());
            end
`ifdef UC_PERF_CNT_EN
            n_tests++;
            if (retired !== 16'(m_retired)) begin
                n_fail++;
                $display("FAIL retired_%0d: got %0d expected %0d", i, retired, m_retired);
            end
`endif
            stopped = m_halted ? stopped + 1 : 0;
            if (stopped > 3) begin
                reset_dut();
                stopped = 0;
            end else @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; Opcode = 6'd0; zero = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu_regreg();
        test_jumps();
        test_run_stall();
        test_halt();
        test_illegal_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
